// File: rtl/gates_mux_alu.sv
// Registered WIDTH-bit bitwise logic unit with an 8-function gate mux, valid/ready
// handshakes, an accumulator fed back as operand A, and a saturating transfer counter.
module gates_mux_alu #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             acc_en,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic [WIDTH-1:0] acc,
   output logic [CNT_W-1:0] op_count
);

   function automatic logic [WIDTH-1:0] gate_fn(input logic [WIDTH-1:0] opa,
                                                input logic [WIDTH-1:0] opb,
                                                input logic [2:0]       sel);
      logic [WIDTH-1:0] r;
      case (sel)
         3'b000:  r = opa & opb;
         3'b001:  r = opa | opb;
         3'b010:  r = opa ^ opb;
         3'b011:  r = ~(opa & opb);
         3'b100:  r = ~(opa | opb);
         3'b101:  r = ~(opa ^ opb);
         3'b110:  r = ~opa;
         default: r = opb;
      endcase
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             accept;
   logic             xfer;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] result;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid_q && out_ready;

   // A pending clear is folded into operand A so an accepted clear+accumulate beat starts from zero.
   assign opa    = acc_en ? (acc_clr ? '0 : acc_q) : a;
   assign result = gate_fn(opa, b, op);

   always_comb begin
      out_valid_d = out_valid_q;
      y_d         = y_q;
      zero_d      = zero_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      if (accept) begin
         out_valid_d = 1'b1;
         y_d         = result;
         zero_d      = (result == '0);
         acc_d       = result;
      end else begin
         if (xfer)
            out_valid_d = 1'b0;
         if (acc_clr)
            acc_d = '0;
      end
      if (xfer)
         cnt_d = sat_inc(cnt_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
         zero_q      <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         zero_q      <= zero_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign zero      = zero_q;
   assign acc       = acc_q;
   assign op_count  = cnt_q;

endmodule

// File: tb/tb_gates_mux_alu.sv
// Directed bench for gates_mux_alu: a WIDTH=8/CNT_W=16 unit plus a CNT_W=2 copy
// driven from the same stimulus to exercise counter saturation.
module tb_gates_mux_alu;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [2:0] op = '0;
   logic       acc_en = 1'b0;
   logic       acc_clr = 1'b0;
   logic       out_ready = 1'b0;

   logic        in_ready, out_valid, zero;
   logic [7:0]  y, acc;
   logic [15:0] op_count;

   logic        in_ready2, out_valid2, zero2;
   logic [7:0]  y2, acc2;
   logic [1:0]  op_count2;

   int errors = 0;
   int checks = 0;

   gates_mux_alu #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero),
      .acc(acc), .op_count(op_count)
   );

   gates_mux_alu #(.WIDTH(8), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
      .out_valid(out_valid2), .out_ready(out_ready), .y(y2), .zero(zero2),
      .acc(acc2), .op_count(op_count2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      op        = '0;
      acc_en    = 1'b0;
      acc_clr   = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   logic [7:0] sweep_exp [8];
   logic [1:0] sat_exp [6];

   initial begin
      sweep_exp = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'h0F};
      sat_exp   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

      // Reset state
      idle_inputs();
      rst = 1'b1;
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_y", y, 0);
      check("rst_zero", zero, 0);
      check("rst_acc", acc, 0);
      check("rst_op_count", op_count, 0);
      check("rst_in_ready", in_ready, 1);
      tick();
      rst = 1'b0;

      // Function sweep
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a = 8'hA5;
      b = 8'h0F;
      for (int i = 0; i < 8; i++) begin
         op = 3'(i);
         tick();
         check($sformatf("sweep_y_op%0d", i), y, sweep_exp[i]);
         check($sformatf("sweep_zero_op%0d", i), zero, 0);
         check($sformatf("sweep_valid_op%0d", i), out_valid, 1);
      end
      in_valid = 1'b0;
      tick();
      check("sweep_op_count", op_count, 8);
      check("sweep_drain_valid", out_valid, 0);
      check("sweep_drain_y_hold", y, 8'h0F);

      // Zero flag
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a = 8'hF0;
      b = 8'h0F;
      op = 3'b000;
      tick();
      check("zero_and_y", y, 8'h00);
      check("zero_and_flag", zero, 1);
      op = 3'b001;
      tick();
      check("zero_or_y", y, 8'hFF);
      check("zero_or_flag", zero, 0);
      in_valid = 1'b0;
      tick();

      // Accumulate
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      acc_en    = 1'b1;
      acc_clr   = 1'b1;
      op = 3'b010;
      a  = 8'h00;
      b  = 8'h01;
      tick();
      check("accum_y1", y, 8'h01);
      check("accum_acc1", acc, 8'h01);
      acc_clr = 1'b0;
      a = 8'hFF;
      b = 8'h02;
      tick();
      check("accum_y2", y, 8'h03);
      b = 8'h04;
      tick();
      check("accum_y3", y, 8'h07);
      check("accum_acc3", acc, 8'h07);
      in_valid = 1'b0;
      acc_en   = 1'b0;
      tick();
      check("accum_acc_hold", acc, 8'h07);

      // Backpressure
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a = 8'h3C;
      b = 8'hFF;
      op = 3'b000;
      tick();
      check("bp_y", y, 8'h3C);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      a = 8'h0F;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("bp_hold_y%0d", i), y, 8'h3C);
         check($sformatf("bp_hold_cnt%0d", i), op_count, 0);
         check($sformatf("bp_hold_acc%0d", i), acc, 8'h3C);
      end
      in_valid = 1'b0;
      acc_clr  = 1'b1;
      tick();
      check("bp_clr_acc", acc, 8'h00);
      check("bp_clr_y_hold", y, 8'h3C);
      check("bp_clr_valid_hold", out_valid, 1);
      acc_clr  = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", in_ready, 1);
      tick();
      check("bp_release_cnt", op_count, 1);
      check("bp_release_y", y, 8'h0F);
      check("bp_release_valid", out_valid, 1);
      in_valid = 1'b0;
      tick();
      check("bp_drain_cnt", op_count, 2);
      check("bp_drain_valid", out_valid, 0);

      // Counter saturation on the CNT_W=2 copy
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a = 8'h12;
      b = 8'h34;
      op = 3'b001;
      tick();
      check("sat_cnt_first", op_count2, 0);
      for (int i = 0; i < 6; i++) begin
         if (i == 5)
            in_valid = 1'b0;
         tick();
         check($sformatf("sat_cnt_%0d", i), op_count2, sat_exp[i]);
      end
      check("sat_wide_cnt", op_count, 6);

      // Reset mid-operation
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a = 8'hAA;
      b = 8'h00;
      op = 3'b001;
      tick();
      check("midrst_pre_y", y, 8'hAA);
      check("midrst_pre_acc", acc, 8'hAA);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_y", y, 0);
      check("midrst_valid", out_valid, 0);
      check("midrst_acc", acc, 0);
      check("midrst_cnt", op_count, 0);
      check("midrst_in_ready", in_ready, 1);
      tick();
      rst = 1'b0;
      a = 8'h11;
      b = 8'h01;
      op = 3'b001;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      check("postrst_y", y, 8'h11);
      check("postrst_valid", out_valid, 1);
      check("postrst_cnt", op_count, 0);
      in_valid = 1'b0;
      tick();
      check("postrst_drain_cnt", op_count, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
